// File: rtl/cpu_control_unit_if.sv
// Control bundle between the SPM CPU controller and its datapath.
// The controller takes the master side; the datapath (or bench) takes the slave side.
interface cpu_control_unit_if;
  logic       start;
  logic [7:0] ir;
  logic       zero;
  logic       load_R0, load_R1, load_R2, load_R3;
  logic       load_PC, inc_PC, load_IR, load_Y, load_Z, load_addr;
  logic [2:0] sel_mux1;
  logic [1:0] sel_mux2;
  logic       mem_write;
  logic       halted;

  modport master (
    input  start, ir, zero,
    output load_R0, load_R1, load_R2, load_R3,
    output load_PC, inc_PC, load_IR, load_Y, load_Z, load_addr,
    output sel_mux1, sel_mux2, mem_write, halted
  );

  modport slave (
    output start, ir, zero,
    input  load_R0, load_R1, load_R2, load_R3,
    input  load_PC, inc_PC, load_IR, load_Y, load_Z, load_addr,
    input  sel_mux1, sel_mux2, mem_write, halted
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit SPM CPU datapath.
// The state register is the only flop; every output decodes from state, ir and zero.
module cpu_control_unit #(
  parameter bit AUTO_START = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  cpu_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_NOT = 4'd4, OP_RD  = 4'd5, OP_WR  = 4'd6, OP_BR  = 4'd7,
                         OP_BRZ = 4'd8;
  localparam logic [2:0] MUX1_PC  = 3'd4;
  localparam logic [1:0] MUX2_ALU = 2'd0, MUX2_BUS1 = 2'd1, MUX2_MEM = 2'd2;

  state_e state_q, state_d;

  logic [3:0] opcode;
  logic [1:0] src, dest;
  assign opcode = bus.ir[7:4];
  assign src    = bus.ir[3:2];
  assign dest   = bus.ir[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start || AUTO_START) state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_NOP, OP_NOT:         state_d = S_FETCH1;
          OP_ADD, OP_SUB, OP_AND: state_d = S_EXEC;
          OP_RD:                  state_d = S_RD1;
          OP_WR:                  state_d = S_WR1;
          OP_BR:                  state_d = S_BR1;
          OP_BRZ:                 state_d = bus.zero ? S_BR1 : S_FETCH1;
          default:                state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = S_FETCH1;
      S_RD1:    state_d = S_RD2;
      S_WR1:    state_d = S_WR2;
      S_BR1:    state_d = S_BR2;
      S_RD2, S_WR2, S_BR2: state_d = S_FETCH1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  logic [3:0] load_r;
  logic       load_pc, inc_pc, load_ir, load_y, load_z, load_addr, mem_write, halted;
  logic [2:0] sel_mux1;
  logic [1:0] sel_mux2;

  always_comb begin
    load_r    = '0;
    load_pc   = 1'b0;
    inc_pc    = 1'b0;
    load_ir   = 1'b0;
    load_y    = 1'b0;
    load_z    = 1'b0;
    load_addr = 1'b0;
    mem_write = 1'b0;
    halted    = 1'b0;
    sel_mux1  = 3'd0;
    sel_mux2  = MUX2_ALU;
    unique case (state_q)
      S_FETCH1: begin
        sel_mux1 = MUX1_PC; sel_mux2 = MUX2_BUS1; load_addr = 1'b1; inc_pc = 1'b1;
      end
      S_FETCH2: begin
        sel_mux2 = MUX2_MEM; load_ir = 1'b1;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            sel_mux1 = {1'b0, src}; sel_mux2 = MUX2_BUS1; load_y = 1'b1;
          end
          OP_NOT: begin
            sel_mux1 = {1'b0, src}; sel_mux2 = MUX2_ALU; load_r[dest] = 1'b1; load_z = 1'b1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_mux1 = MUX1_PC; sel_mux2 = MUX2_BUS1; load_addr = 1'b1; inc_pc = 1'b1;
          end
          OP_BRZ: begin
            // Not taken: just step PC past the address byte.
            inc_pc = 1'b1;
            if (bus.zero) begin
              sel_mux1 = MUX1_PC; sel_mux2 = MUX2_BUS1; load_addr = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        sel_mux1 = {1'b0, dest}; sel_mux2 = MUX2_ALU; load_r[dest] = 1'b1; load_z = 1'b1;
      end
      S_RD1, S_WR1, S_BR1: begin
        sel_mux2 = MUX2_MEM; load_addr = 1'b1;
      end
      S_RD2: begin
        sel_mux2 = MUX2_MEM; load_r[dest] = 1'b1;
      end
      S_WR2: begin
        sel_mux1 = {1'b0, src}; mem_write = 1'b1;
      end
      S_BR2: begin
        sel_mux2 = MUX2_MEM; load_pc = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.load_R0   = load_r[0];
  assign bus.load_R1   = load_r[1];
  assign bus.load_R2   = load_r[2];
  assign bus.load_R3   = load_r[3];
  assign bus.load_PC   = load_pc;
  assign bus.inc_PC    = inc_pc;
  assign bus.load_IR   = load_ir;
  assign bus.load_Y    = load_y;
  assign bus.load_Z    = load_z;
  assign bus.load_addr = load_addr;
  assign bus.sel_mux1  = sel_mux1;
  assign bus.sel_mux2  = sel_mux2;
  assign bus.mem_write = mem_write;
  assign bus.halted    = halted;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: walks each instruction class cycle by cycle.
module tb_cpu_control_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cpu_control_unit_if bus ();
  cpu_control_unit #(.AUTO_START(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  // {load_R3..R0, load_PC, inc_PC, load_IR, load_Y, load_Z, load_addr, sel_mux1, sel_mux2, mem_write, halted}
  function automatic logic [16:0] pack();
    return {bus.load_R3, bus.load_R2, bus.load_R1, bus.load_R0,
            bus.load_PC, bus.inc_PC, bus.load_IR, bus.load_Y, bus.load_Z, bus.load_addr,
            bus.sel_mux1, bus.sel_mux2, bus.mem_write, bus.halted};
  endfunction

  function automatic logic [16:0] mk(input logic [3:0] lr, input logic pc, input logic inc,
                                     input logic irl, input logic y, input logic z,
                                     input logic addr, input logic [2:0] m1,
                                     input logic [1:0] m2, input logic mw, input logic h);
    return {lr, pc, inc, irl, y, z, addr, m1, m2, mw, h};
  endfunction

  logic [16:0] E_ZERO, E_FETCH1, E_FETCH2, E_ADDR2, E_HALT;

  task automatic chk(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = pack();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [7:0] instr);
    chk("fetch1", E_FETCH1);
    cyc();
    chk("fetch2", E_FETCH2);
    bus.ir = instr;
    cyc();
  endtask

  initial begin
    E_ZERO   = mk(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0);
    E_FETCH1 = mk(4'b0000, 0, 1, 0, 0, 0, 1, 3'd4, 2'd1, 0, 0);
    E_FETCH2 = mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
    E_ADDR2  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 3'd0, 2'd2, 0, 0);
    E_HALT   = mk(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1);

    rst = 1'b0; bus.start = 1'b0; bus.ir = 8'h00; bus.zero = 1'b0;
    #3 chk("reset", E_ZERO);
    cyc(); cyc();
    chk("reset_clocked", E_ZERO);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(); chk("idle_no_start", E_ZERO); end

    bus.start = 1'b1;
    #1 chk("idle_start_high", E_ZERO);
    cyc();
    bus.start = 1'b0;

    // ADD src=R1 dest=R2
    fetch(8'h16);
    chk("add_decode", mk(4'b0000, 0, 0, 0, 1, 0, 0, 3'd1, 2'd1, 0, 0));
    cyc();
    chk("add_exec", mk(4'b0100, 0, 0, 0, 0, 1, 0, 3'd2, 2'd0, 0, 0));
    cyc();

    // RD dest=R3
    fetch(8'h53);
    chk("rd_decode", E_FETCH1);
    cyc(); chk("rd1", E_ADDR2);
    cyc(); chk("rd2", mk(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    cyc();

    // WR src=R1
    fetch(8'h64);
    chk("wr_decode", E_FETCH1);
    cyc(); chk("wr1", E_ADDR2);
    cyc(); chk("wr2", mk(4'b0000, 0, 0, 0, 0, 0, 0, 3'd1, 2'd0, 1, 0));
    cyc();

    // BRZ taken
    bus.zero = 1'b1;
    fetch(8'h80);
    chk("brz_t_decode", E_FETCH1);
    cyc(); chk("br1", E_ADDR2);
    cyc(); chk("br2", mk(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    cyc();

    // BRZ not taken
    bus.zero = 1'b0;
    fetch(8'h80);
    chk("brz_nt_decode", mk(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
    cyc();

    // NOT src=R3 dest=R2
    fetch(8'h4E);
    chk("not_decode", mk(4'b0100, 0, 0, 0, 0, 1, 0, 3'd3, 2'd0, 0, 0));
    cyc();

    // SUB src=R3 dest=R1
    fetch(8'h2D);
    chk("sub_decode", mk(4'b0000, 0, 0, 0, 1, 0, 0, 3'd3, 2'd1, 0, 0));
    cyc();
    chk("sub_exec", mk(4'b0010, 0, 0, 0, 0, 1, 0, 3'd1, 2'd0, 0, 0));
    cyc();

    // NOP
    fetch(8'h00);
    chk("nop_decode", E_ZERO);
    cyc();

    // Reset mid-instruction aborts into IDLE
    fetch(8'h53);
    cyc();
    chk("rd1_before_abort", E_ADDR2);
    #1 rst = 1'b0;
    #1 chk("abort_async", E_ZERO);
    cyc(); chk("abort_held", E_ZERO);
    rst = 1'b1;
    cyc(); chk("abort_idle", E_ZERO);

    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;

    // Illegal opcode halts
    fetch(8'hF0);
    chk("illegal_decode", E_ZERO);
    for (int i = 0; i < 12; i++) begin cyc(); chk("halt", E_HALT); end
    #1 rst = 1'b0;
    #1 chk("halt_async_reset", E_ZERO);
    cyc(); chk("halt_reset_held", E_ZERO);
    rst = 1'b1;
    cyc(); chk("halt_to_idle", E_ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
